// File: rtl/feed_scheduler.sv
// -----------------------------------------------------------------------------
// feed_scheduler
//
// Top-level sequencer for the pet-feeder dispense path. A feed starts on a
// manual request, a queued request, or the periodic auto-feed timer. The
// dispenser motor then runs for at most FOOD_TIME cycles. A full bowl ends the
// dispense early. An empty tank aborts it and latches an alarm until the
// operator acknowledges it. After each feed the motor stays off for
// SETTLE_TIME cycles. A saturating counter records the completed feeds.
//
// Ports
//   clock              in   1  system clock, rising edge
//   reset              in   1  asynchronous, active-low; clears all state
//   start              in   1  manual feed request (level)
//   auto_en            in   1  enables the periodic auto-feed timer
//   full_bowl_sensor   in   1  bowl full: ends a dispense, blocks a new one
//   empty_tank_sensor  in   1  tank empty: aborts a dispense, raises the alarm
//   ack_alarm          in   1  operator acknowledge (honoured only if tank refilled)
//   motor_on           out  1  dispenser motor drive
//   busy               out  1  high in DISPENSE or SETTLE
//   alarm              out  1  high in ALARM
//   pending            out  1  one manual request is queued
//   last_dispense      out  8  motor-on cycles of the most recent feed
//   feeds_done         out  8  completed feeds, saturating at 255
//   state_out          out  3  IDLE=0, DISPENSE=1, SETTLE=2, ALARM=3
// -----------------------------------------------------------------------------
module feed_scheduler #(
    parameter int FOOD_TIME   = 10,
    parameter int SETTLE_TIME = 4,
    parameter int INTERVAL    = 50
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       auto_en,
    input  logic       full_bowl_sensor,
    input  logic       empty_tank_sensor,
    input  logic       ack_alarm,
    output logic       motor_on,
    output logic       busy,
    output logic       alarm,
    output logic       pending,
    output logic [7:0] last_dispense,
    output logic [7:0] feeds_done,
    output logic [2:0] state_out
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DISPENSE = 3'd1,
        SETTLE   = 3'd2,
        ALARM    = 3'd3
    } state_t;

    localparam logic [7:0]  DISP_LAST    = 8'(FOOD_TIME);
    localparam logic [7:0]  SETTLE_LAST  = 8'(SETTLE_TIME);
    localparam logic [15:0] TIMER_RELOAD = 16'(INTERVAL - 1);

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [7:0]  disp_cnt_q, disp_cnt_d;
    logic [7:0]  settle_cnt_q, settle_cnt_d;
    logic        pending_d;
    logic [7:0]  last_d;
    logic [7:0]  feeds_d;

    logic feed_trigger;

    // Auto-feed fires once the interval timer has run down to zero.
    assign feed_trigger = start | pending | (auto_en && timer_q == 16'd0);

    // Next-state and next-value logic for every register.
    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_d      = state_q;
        timer_d      = timer_q;
        disp_cnt_d   = disp_cnt_q;
        settle_cnt_d = settle_cnt_q;
        pending_d    = pending;
        last_d       = last_dispense;
        feeds_d      = feeds_done;

        unique case (state_q)
            IDLE: begin
                if (empty_tank_sensor) begin
                    state_d   = ALARM;
                    pending_d = 1'b0;
                end else if (full_bowl_sensor) begin
                    // Feeding is blocked; a request is queued, the timer
                    // keeps running but parks at zero once expired.
                    pending_d = pending | start;
                    if (auto_en && timer_q != 16'd0)
                        timer_d = timer_q - 16'd1;
                end else if (feed_trigger) begin
                    state_d    = DISPENSE;
                    timer_d    = TIMER_RELOAD;
                    pending_d  = 1'b0;
                    disp_cnt_d = 8'd1;
                end else if (auto_en) begin
                    // timer_q is non-zero here, otherwise feed_trigger fired.
                    timer_d = timer_q - 16'd1;
                end
            end

            DISPENSE: begin
                pending_d = pending | start;
                if (empty_tank_sensor) begin
                    state_d   = ALARM;
                    last_d    = disp_cnt_q;
                    pending_d = 1'b0;
                end else if (full_bowl_sensor || disp_cnt_q == DISP_LAST) begin
                    state_d      = SETTLE;
                    last_d       = disp_cnt_q;
                    settle_cnt_d = 8'd1;
                    if (feeds_done != 8'hFF)
                        feeds_d = feeds_done + 8'd1;
                end else begin
                    disp_cnt_d = disp_cnt_q + 8'd1;
                end
            end

            SETTLE: begin
                pending_d = pending | start;
                if (empty_tank_sensor) begin
                    state_d   = ALARM;
                    pending_d = 1'b0;
                end else if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = IDLE;
                end else begin
                    settle_cnt_d = settle_cnt_q + 8'd1;
                end
            end

            ALARM: begin
                // Acknowledge is only honoured on a cycle where the tank is
                // already refilled; an early ack is simply dropped.
                pending_d = 1'b0;
                if (ack_alarm && !empty_tank_sensor) begin
                    state_d = IDLE;
                    timer_d = TIMER_RELOAD;
                end
            end

            default: begin
                state_d   = IDLE;
                pending_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; the status outputs are registered from
    // the next state so they line up with state_out.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            timer_q       <= TIMER_RELOAD;
            disp_cnt_q    <= 8'd0;
            settle_cnt_q  <= 8'd0;
            pending       <= 1'b0;
            last_dispense <= 8'd0;
            feeds_done    <= 8'd0;
            motor_on      <= 1'b0;
            busy          <= 1'b0;
            alarm         <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q       <= state_d;
            timer_q       <= timer_d;
            disp_cnt_q    <= disp_cnt_d;
            settle_cnt_q  <= settle_cnt_d;
            pending       <= pending_d;
            last_dispense <= last_d;
            feeds_done    <= feeds_d;
            motor_on      <= (state_d == DISPENSE);
            busy          <= (state_d == DISPENSE) || (state_d == SETTLE);
            alarm         <= (state_d == ALARM);
        end
    end

    assign state_out = state_q;

endmodule

// File: tb/tb_feed_scheduler.sv
// -----------------------------------------------------------------------------
// tb_feed_scheduler
//
// Self-checking bench for feed_scheduler. A behavioural model advances once
// per clock edge and pushes the outputs it predicts into a scoreboard queue;
// a monitor pops and compares them on the falling edge. Directed scenarios
// add spot checks against fixed values.
// -----------------------------------------------------------------------------
module tb_feed_scheduler;

    localparam int FOOD_TIME   = 10;
    localparam int SETTLE_TIME = 4;
    localparam int INTERVAL    = 50;

    typedef struct packed {
        logic       motor_on;
        logic       busy;
        logic       alarm;
        logic       pending;
        logic [7:0] last_dispense;
        logic [7:0] feeds_done;
        logic [2:0] state_out;
    } obs_t;

    logic       clock;
    logic       reset;
    logic       start;
    logic       auto_en;
    logic       full_bowl_sensor;
    logic       empty_tank_sensor;
    logic       ack_alarm;
    logic       motor_on;
    logic       busy;
    logic       alarm;
    logic       pending;
    logic [7:0] last_dispense;
    logic [7:0] feeds_done;
    logic [2:0] state_out;

    int n_checks = 0;
    int n_errors = 0;

    obs_t sb[$];

    feed_scheduler #(
        .FOOD_TIME  (FOOD_TIME),
        .SETTLE_TIME(SETTLE_TIME),
        .INTERVAL   (INTERVAL)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .auto_en          (auto_en),
        .full_bowl_sensor (full_bowl_sensor),
        .empty_tank_sensor(empty_tank_sensor),
        .ack_alarm        (ack_alarm),
        .motor_on         (motor_on),
        .busy             (busy),
        .alarm            (alarm),
        .pending          (pending),
        .last_dispense    (last_dispense),
        .feeds_done       (feeds_done),
        .state_out        (state_out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- behavioural reference model ----------------
    // mode: 0 idle, 1 dispensing, 2 settling, 3 alarm
    int m_mode;
    int m_motor_cycles;   // motor cycles used so far in this feed
    int m_settle_left;    // settle cycles still to run
    int m_wait;           // idle cycles still to wait before an auto feed
    bit m_pending;
    int m_last;
    int m_feeds;

    task automatic model_reset();
        m_mode         = 0;
        m_motor_cycles = 0;
        m_settle_left  = 0;
        m_wait         = INTERVAL - 1;
        m_pending      = 0;
        m_last         = 0;
        m_feeds        = 0;
    endtask

    task automatic finish_feed();
        m_last = m_motor_cycles;
        if (m_feeds < 255) m_feeds++;
        m_mode        = 2;
        m_settle_left = SETTLE_TIME;
    endtask

    task automatic model_step();
        if (m_mode == 0) begin
            if (empty_tank_sensor) begin
                m_mode    = 3;
                m_pending = 0;
            end else if (full_bowl_sensor) begin
                if (start) m_pending = 1;
                if (auto_en && m_wait > 0) m_wait--;
            end else if (start || m_pending || (auto_en && m_wait == 0)) begin
                m_mode         = 1;
                m_motor_cycles = 1;
                m_wait         = INTERVAL - 1;
                m_pending      = 0;
            end else if (auto_en) begin
                m_wait--;
            end
        end else if (m_mode == 1) begin
            if (start) m_pending = 1;
            if (empty_tank_sensor) begin
                m_last    = m_motor_cycles;
                m_mode    = 3;
                m_pending = 0;
            end else if (full_bowl_sensor || m_motor_cycles == FOOD_TIME) begin
                finish_feed();
            end else begin
                m_motor_cycles++;
            end
        end else if (m_mode == 2) begin
            if (start) m_pending = 1;
            if (empty_tank_sensor) begin
                m_mode    = 3;
                m_pending = 0;
            end else begin
                m_settle_left--;
                if (m_settle_left == 0) m_mode = 0;
            end
        end else begin
            m_pending = 0;
            if (ack_alarm && !empty_tank_sensor) begin
                m_mode = 0;
                m_wait = INTERVAL - 1;
            end
        end
    endtask

    function automatic obs_t model_out();
        obs_t o;
        o.motor_on      = (m_mode == 1);
        o.busy          = (m_mode == 1) || (m_mode == 2);
        o.alarm         = (m_mode == 3);
        o.pending       = m_pending;
        o.last_dispense = 8'(m_last);
        o.feeds_done    = 8'(m_feeds);
        o.state_out     = 3'(m_mode);
        return o;
    endfunction

    // ---------------- monitor ----------------
    initial begin
        obs_t exp_o;
        obs_t act_o;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                exp_o = sb.pop_front();
                act_o = '{motor_on, busy, alarm, pending, last_dispense, feeds_done, state_out};
                n_checks++;
                if (act_o !== exp_o) begin
                    n_errors++;
                    $display("FAIL outputs @%0t: got motor=%b busy=%b alarm=%b pend=%b last=%0d feeds=%0d st=%0d, expected motor=%b busy=%b alarm=%b pend=%b last=%0d feeds=%0d st=%0d",
                             $time, act_o.motor_on, act_o.busy, act_o.alarm, act_o.pending,
                             act_o.last_dispense, act_o.feeds_done, act_o.state_out,
                             exp_o.motor_on, exp_o.busy, exp_o.alarm, exp_o.pending,
                             exp_o.last_dispense, exp_o.feeds_done, exp_o.state_out);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One clock edge: advance the model with the inputs the DUT samples,
    // queue the prediction, then return 2 time units after the edge.
    task automatic tick();
        @(posedge clock);
        if (!reset) model_reset();
        else        model_step();
        sb.push_back(model_out());
        #2;
    endtask

    // Assert reset between edges; outputs must clear without a clock edge.
    task automatic assert_reset_async();
        reset = 1'b0;
        model_reset();
        sb.delete();
        sb.push_back(model_out());
    endtask

    task automatic wait_idle(input string name);
        int c = 0;
        while (state_out != 3'd0 && c < 200) begin
            tick();
            c++;
        end
        if (c >= 200) check(name, int'(state_out), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c;
        int seen;
        int f0;

        reset             = 1'b0;
        start             = 1'b0;
        auto_en           = 1'b0;
        full_bowl_sensor  = 1'b0;
        empty_tank_sensor = 1'b0;
        ack_alarm         = 1'b0;
        model_reset();

        // 1. reset, then a single full-length feed
        repeat (3) tick();
        reset = 1'b1;
        check("reset_outputs",
              int'({motor_on, busy, alarm, pending, last_dispense, feeds_done, state_out}), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        while (motor_on && c < 30) begin c++; tick(); end
        check("t1_motor_cycles", c, FOOD_TIME);
        c = 0;
        while (busy && c < 30) begin c++; tick(); end
        check("t1_settle_cycles", c, SETTLE_TIME);
        check("t1_feeds_done", int'(feeds_done), 1);
        check("t1_last_dispense", int'(last_dispense), FOOD_TIME);

        // 2. full bowl on the 4th motor cycle, then a blocked request
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        full_bowl_sensor = 1'b1;
        tick();
        check("t2_motor_dropped", int'(motor_on), 0);
        check("t2_last_dispense", int'(last_dispense), 4);
        check("t2_feeds_done", int'(feeds_done), 2);
        c = 0;
        while (busy && c < 30) begin c++; tick(); end
        check("t2_settle_cycles", c, SETTLE_TIME);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("t2_blocked_idle", int'(state_out), 0);
        check("t2_pending_queued", int'(pending), 1);
        full_bowl_sensor = 1'b0;
        tick();
        check("t2_queued_feed_starts", int'(motor_on), 1);
        check("t2_pending_cleared", int'(pending), 0);
        c = 0;
        while (busy && c < 40) begin c++; tick(); end

        // 3. empty tank at motor cycle 6, ignored early ack, then recovery
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        empty_tank_sensor = 1'b1;
        tick();
        check("t3_alarm", int'(alarm), 1);
        check("t3_motor_off", int'(motor_on), 0);
        check("t3_last_dispense", int'(last_dispense), 6);
        check("t3_feeds_unchanged", int'(feeds_done), 3);
        ack_alarm = 1'b1;
        tick();
        ack_alarm = 1'b0;
        empty_tank_sensor = 1'b0;
        tick();
        check("t3_early_ack_ignored", int'(state_out), 3);
        ack_alarm = 1'b1;
        tick();
        ack_alarm = 1'b0;
        check("t3_ack_to_idle", int'(state_out), 0);
        check("t3_alarm_cleared", int'(alarm), 0);

        // 4. auto-feed timing from reset, period, freeze and resume
        assert_reset_async();
        auto_en = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        c = 0;
        while (!motor_on && c < 200) begin tick(); c++; end
        check("t4_first_auto_feed", c, INTERVAL);
        c = 0;
        do begin tick(); c++; end while (motor_on && c < 200);
        while (!motor_on && c < 200) begin tick(); c++; end
        check("t4_auto_period", c, INTERVAL + FOOD_TIME + SETTLE_TIME);
        wait_idle("t4_reach_idle");
        repeat (10) tick();
        auto_en = 1'b0;
        seen = 0;
        repeat (120) begin tick(); if (motor_on) seen = 1; end
        check("t4_frozen_no_feed", seen, 0);
        auto_en = 1'b1;
        c = 0;
        while (!motor_on && c < 200) begin tick(); c++; end
        check("t4_resume_remaining", c, INTERVAL - 10);
        auto_en = 1'b0;
        c = 0;
        while (busy && c < 40) begin c++; tick(); end

        // 5. requests during DISPENSE and SETTLE queue exactly one feed
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        while (state_out != 3'd2 && c < 40) begin tick(); c++; end
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_pending_single", int'(pending), 1);
        f0 = int'(feeds_done);
        wait_idle("t5_reach_idle");
        tick();
        check("t5_extra_feed_starts", int'(motor_on), 1);
        c = 0;
        while (busy && c < 40) begin c++; tick(); end
        repeat (20) tick();
        check("t5_exactly_one_extra", int'(feeds_done), f0 + 1);
        check("t5_pending_drained", int'(pending), 0);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            start             = ($urandom_range(0, 99) < 15);
            full_bowl_sensor  = ($urandom_range(0, 99) < 10);
            empty_tank_sensor = ($urandom_range(0, 99) < 4);
            ack_alarm         = ($urandom_range(0, 99) < 25);
            if ($urandom_range(0, 99) < 3) auto_en = ~auto_en;
            tick();
        end

        // 6. saturation of the feed counter, then reset mid-dispense
        start             = 1'b1;
        empty_tank_sensor = 1'b0;
        ack_alarm         = 1'b1;
        auto_en           = 1'b0;
        c = 0;
        while (feeds_done != 8'hFF && c < 12000) begin
            full_bowl_sensor = ($urandom_range(0, 99) < 20);
            tick();
            c++;
        end
        check("t6_reached_255", int'(feeds_done), 255);
        full_bowl_sensor = 1'b0;
        repeat (60) tick();
        check("t6_saturated", int'(feeds_done), 255);
        c = 0;
        while (!motor_on && c < 40) begin tick(); c++; end
        repeat (2) tick();
        check("t6_mid_dispense", int'(motor_on), 1);
        #1;
        assert_reset_async();
        start = 1'b0;
        #1;
        check("t6_async_motor_off", int'(motor_on), 0);
        check("t6_async_feeds_clear", int'(feeds_done), 0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (5) tick();

        @(negedge clock);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
